aes_key_expand_multi: RTL and testbench
=======================================

Name: aes_key_expand_multi

Overview:
- Parametrised successor to the fixed AES-128 round-key generator.
- Supports AES-128, AES-192 and AES-256, selected per job at run time.
- Generates one 32-bit schedule word per clock and packs the words into 128-bit round keys.
- Streams round keys to the cipher datapath over a valid/ready handshake, in encryption order, each tagged with its round index.

Parameters:
- KEY_MAX_BITS, 256: widest supported key (128, 192 or 256). Sets key_in width and the sliding-window depth (KEY_MAX_BITS/32 words).
- OUT_REG, 1: 1 = round-key output is registered (skid stage); 0 = the collector drives the outputs directly.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous, active-high reset
- start_in  in  1  start pulse; sampled only in IDLE
- key_len_in  in  2  00=128, 01=192, 10=256, 11=illegal; sampled with start_in
- key_in  in  KEY_MAX_BITS  cipher key, MSB-aligned; word 0 = most significant 32 bits
- rk_valid_out  out  1  round key available
- rk_ready_in  in  1  consumer accepts the round key
- rk_out  out  128  round key; word 0 in [127:96]
- rk_idx_out  out  4  round number 0..Nr
- rk_last_out  out  1  high with round key Nr
- state_out  out  2  FSM state
- busy_out  out  1  state != IDLE

Behaviour:
- Reset is asynchronous, active-high. All outputs go to 0, state goes to IDLE, the window and Rcon registers are cleared. Reset mid-job aborts the job; no partial key survives.
- Mode constants:
  - Nk = 4/6/8 and Nr = 10/12/14 for 128/192/256.
  - Total words = 4*(Nr+1) = 44/52/60.
- FSM, encoded IDLE=0, LOAD=1, EXPAND=2, DRAIN=3:
  - IDLE: on start_in=1 with a legal mode, latch the key and mode, go to LOAD. start_in in any other state is ignored.
  - LOAD: emit key words 0..Nk-1, one per cycle, into the collector and window; then go to EXPAND.
  - EXPAND: compute w[i] for i=Nk..4(Nr+1)-1, one per cycle:
    - temp = w[i-1].
    - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {Rcon,24'h0}.
    - Else if Nk==8 and i mod 8 == 4: temp = SubWord(temp).
    - w[i] = w[i-Nk] ^ temp.
    - After the final word, go to DRAIN.
  - DRAIN: wait for the handshake of the round key with rk_last_out=1, then go to IDLE.
- Arithmetic:
  - "i mod Nk" is a modular counter (0..Nk-1); no dividers.
  - Rcon starts at 8'h01 and updates by GF(2^8) xtime (shift left, XOR 8'h1B on carry) after each use.
  - The window is a shift register of KEY_MAX_BITS/32 words; w[i-Nk] is read at tap Nk-1.
- Collector and handshake:
  - The collector accumulates 4 words, then presents a round key.
  - rk_out, rk_idx_out and rk_last_out are stable while rk_valid_out=1 and rk_ready_in=0.
  - A transfer occurs on a cycle with rk_valid_out and rk_ready_in both high.
  - The engine stalls (holds word index, window and Rcon) only while the output is full, unaccepted, and the collector is also full.
- Latency and throughput:
  - With OUT_REG=1 and rk_ready_in held at 1: rk_valid_out for round key 0 rises 5 cycles after the start edge.
  - One round key follows every 4 cycles, with no bubbles.
  - OUT_REG=0 removes one cycle of latency.
- Illegal mode: key_len_in=11, or a mode wider than KEY_MAX_BITS, is ignored and the block stays in IDLE (see the optional feature).
- Simultaneous events: rk_ready_in in the same cycle as the last transfer moves DRAIN to IDLE; a start_in on that same edge is ignored, since it is sampled only in IDLE.

Optional Feature:
- AES_KEY_EXPAND_ERR_EN.
- Defined:
  - Adds output err_out (1 bit, resets to 0).
  - A start with an illegal mode sets err_out sticky high; it clears on the next legal start or on RST.
  - The FSM stays in IDLE.
- Undefined:
  - No err_out port.
  - Illegal starts are silently dropped.

Decomposition:
- Shared package aes_pkg:
  - key-length enum (AES128/192/256)
  - NK/NR lookup functions
  - FSM state constants
  - RCON_INIT = 8'h01 and the xtime function
- One sub-module, aes_sbox: combinational 8-bit S-box, instanced 4x for SubWord. Shared later with the cipher's SubBytes.

Test Plan:
- AES-128 key 5468617473206D79204B756E67204675, rk_ready_in=1 -> 11 keys; idx0 = key; idx1 = E232FCF191129188B159E4E6D679A293; idx10 = 28FDDEF86DA4244ACCC0A4FE3B316F26 with rk_last_out=1; then state IDLE.
- AES-192 key 8E73B0F7DA0E6452C810F32B809079E562F8EAD2522C6B7B -> 13 keys; w[6] = FE0C91F7; idx12 = E98BA06F448C773C8ECC720401002202.
- AES-256 key 603DEB1015CA71BE2B73AEF0857D77811F352C073B6108D72D9810A30914DFF4 -> 15 keys; idx1 = 1F352C073B6108D72D9810A30914DFF4; w[8] = 9BA35411; idx14 = FE4890D1E6188D0B046DF344706C631E.
- Backpressure: random rk_ready_in (50%) on the AES-256 job -> same 15 keys in order; rk_out stable whenever valid and not ready; no index skipped.
- Abort: RST asserted during EXPAND of round 6 -> outputs 0 and state 0 immediately; a new AES-128 start then produces the correct idx0..10.
- Illegal mode: key_len_in=11 with start_in -> stays IDLE, rk_valid_out=0; with AES_KEY_EXPAND_ERR_EN, err_out=1 until the next legal start.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule types, per-mode constants and GF(2^8) helpers.
package aes_pkg;

    typedef enum logic [1:0] {AES128 = 2'd0, AES192 = 2'd1, AES256 = 2'd2} key_len_e;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EXPAND = 2'd2, DRAIN = 2'd3} state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        return (kl == 2'd2) ? 4'd8 : (kl == 2'd1) ? 4'd6 : 4'd4;
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        return (kl == 2'd2) ? 4'd14 : (kl == 2'd1) ? 4'd12 : 4'd10;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box, byte x maps to y.
module aes_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);

    localparam logic [2047:0] T = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = T[{~x, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand_multi.sv
// aes_key_expand_multi: run-time AES-128/192/256 key schedule, one word per clock, streamed as round keys.
// Optional AES_KEY_EXPAND_ERR_EN adds a sticky err_out flag for illegal-mode starts.
module aes_key_expand_multi
    import aes_pkg::*;
#(
    parameter int KEY_MAX_BITS = 256,
    parameter bit OUT_REG      = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start_in,
    input  logic [1:0]              key_len_in,
    input  logic [KEY_MAX_BITS-1:0] key_in,
    output logic                    rk_valid_out,
    input  logic                    rk_ready_in,
    output logic [127:0]            rk_out,
    output logic [3:0]              rk_idx_out,
    output logic                    rk_last_out,
    output logic [1:0]              state_out,
    output logic                    busy_out
`ifdef AES_KEY_EXPAND_ERR_EN
    ,output logic                   err_out
`endif
);

    localparam int NW = KEY_MAX_BITS / 32;
    localparam int IW = $clog2(KEY_MAX_BITS);

    state_e                  state, state_nx;
    key_len_e                kl;
    logic [KEY_MAX_BITS-1:0] key_r;
    logic [NW*32-1:0]        win;
    logic [7:0]              rcon;
    logic [5:0]              wi, last_wi;
    logic [2:0]              m;
    logic [3:0]              nk, nr;
    logic [IW-1:0]           tap;
    logic [31:0]             rot_in, sub, temp, w;
    logic [127:0]            col;
    logic [2:0]              col_cnt;
    logic [3:0]              col_idx;
    logic                    legal, accept, gen, take, col_full, stall, xfer;

    assign nk       = nk_of(kl);
    assign nr       = nr_of(kl);
    assign last_wi  = {nr + 4'd1, 2'b00} - 6'd1;
    assign tap      = IW'(32 * (int'(nk) - 1));
    assign legal    = key_len_in != 2'd3 && 32 * int'(nk_of(key_len_in)) <= KEY_MAX_BITS;
    assign accept   = state == IDLE && start_in && legal;
    assign col_full = col_cnt == 3'd4;
    assign stall    = col_full && !take;
    assign gen      = (state == LOAD || state == EXPAND) && !stall;
    assign xfer     = rk_valid_out && rk_ready_in;
    assign state_out = state;
    assign busy_out  = state != IDLE;

    // Rotation only on the Nk boundary; SubWord is shared by both substitution cases.
    for (genvar b = 0; b < 4; b++) begin : g_sb
        aes_sbox u_sbox (.x(rot_in[8*b +: 8]), .y(sub[8*b +: 8]));
    end

    always_comb begin
        rot_in = (m == 3'd0) ? {win[23:0], win[31:24]} : win[31:0];
        temp   = (m == 3'd0) ? sub ^ {rcon, 24'h0} : (nk == 4'd8 && m == 3'd4) ? sub : win[31:0];
        w      = (state == LOAD) ? key_r[KEY_MAX_BITS-1 -: 32] : win[tap +: 32] ^ temp;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? LOAD : IDLE;
            LOAD:    state_nx = (gen && wi == 6'(nk - 4'd1)) ? EXPAND : LOAD;
            EXPAND:  state_nx = (gen && wi == last_wi) ? DRAIN : EXPAND;
            DRAIN:   state_nx = (xfer && rk_last_out) ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    // win[31:0] holds w[i-1]; older words sit at successively higher taps.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            kl    <= AES128;
            key_r <= '0;
            win   <= '0;
            rcon  <= '0;
            wi    <= '0;
            m     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                kl    <= key_len_e'(key_len_in);
                key_r <= key_in;
                rcon  <= RCON_INIT;
                wi    <= '0;
                m     <= '0;
            end else if (gen) begin
                key_r <= key_r << 32;
                win   <= {win[NW*32-33:0], w};
                wi    <= wi + 6'd1;
                m     <= (m == 3'(nk - 4'd1)) ? 3'd0 : m + 3'd1;
                if (state == EXPAND && m == 3'd0)
                    rcon <= xtime(rcon);
            end
        end
    end

    // A full collector can hand off and start refilling on the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            col     <= '0;
            col_cnt <= '0;
            col_idx <= '0;
        end else if (state == IDLE) begin
            col_cnt <= '0;
            col_idx <= '0;
        end else begin
            if (gen)
                col <= {col[95:0], w};
            col_cnt <= take ? 3'(gen) : col_cnt + 3'(gen);
            if (take)
                col_idx <= col_idx + 4'd1;
        end
    end

    if (OUT_REG) begin : g_out_reg
        assign take = col_full && (!rk_valid_out || rk_ready_in);
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                rk_valid_out <= 1'b0;
                rk_out       <= '0;
                rk_idx_out   <= '0;
                rk_last_out  <= 1'b0;
            end else if (take) begin
                rk_valid_out <= 1'b1;
                rk_out       <= col;
                rk_idx_out   <= col_idx;
                rk_last_out  <= col_idx == nr;
            end else if (rk_ready_in) begin
                rk_valid_out <= 1'b0;
            end
        end
    end else begin : g_out_comb
        assign take         = col_full && rk_ready_in;
        assign rk_valid_out = col_full;
        assign rk_out       = col;
        assign rk_idx_out   = col_idx;
        assign rk_last_out  = col_full && col_idx == nr;
    end

`ifdef AES_KEY_EXPAND_ERR_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            err_out <= 1'b0;
        else if (state == IDLE && start_in)
            err_out <= !legal;
    end
`endif

endmodule

// File: tb/tb_aes_key_expand_multi.sv
// tb_aes_key_expand_multi: scoreboard bench for the multi-mode AES key schedule.
module tb_aes_key_expand_multi;

    localparam bit OUT_REG = 1;

    typedef struct packed {
        logic [127:0] rk;
        logic [3:0]   idx;
        logic         last;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         start_in = 1'b0;
    logic [1:0]   key_len_in = 2'd0;
    logic [255:0] key_in = '0;
    logic         rk_valid_out;
    logic         rk_ready_in = 1'b0;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx_out;
    logic         rk_last_out;
    logic [1:0]   state_out;
    logic         busy_out;
`ifdef AES_KEY_EXPAND_ERR_EN
    logic         err_out;
`endif

    int checks = 0;
    int errors = 0;
    exp_t q[$];
    logic [127:0] got [0:15];

    localparam logic [255:0] K128 = {128'h5468617473206D79204B756E67204675, 128'h0};
    localparam logic [255:0] K192 = {192'h8E73B0F7DA0E6452C810F32B809079E562F8EAD2522C6B7B, 64'h0};
    localparam logic [255:0] K256 = 256'h603DEB1015CA71BE2B73AEF0857D77811F352C073B6108D72D9810A30914DFF4;

    aes_key_expand_multi #(.KEY_MAX_BITS(256), .OUT_REG(OUT_REG)) dut (
        .CLK(CLK), .RST(RST), .start_in(start_in), .key_len_in(key_len_in), .key_in(key_in),
        .rk_valid_out(rk_valid_out), .rk_ready_in(rk_ready_in), .rk_out(rk_out),
        .rk_idx_out(rk_idx_out), .rk_last_out(rk_last_out), .state_out(state_out),
        .busy_out(busy_out)
`ifdef AES_KEY_EXPAND_ERR_EN
        , .err_out(err_out)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] gm(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a, p;
        a = a_in;
        p = '0;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Independent S-box: multiplicative inverse by search, then the affine map.
    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] v, s;
        v = '0;
        for (int c = 1; c < 256; c++) if (gm(x, 8'(c)) == 8'h01) v = 8'(c);
        s = 8'h63 ^ v;
        for (int k = 1; k < 5; k++) s ^= 8'((v << k) | (v >> (8 - k)));
        return s;
    endfunction

    function automatic logic [31:0] sw(input logic [31:0] t);
        return {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
    endfunction

    task automatic push_model(input logic [255:0] key, input logic [1:0] kl);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        exp_t        e;
        int          nk, nr;
        nk = 4 + 2 * int'(kl);
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end else if (nk == 8 && i % 8 == 4) begin
                t = sw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            e.rk   = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            e.idx  = 4'(r);
            e.last = (r == nr);
            q.push_back(e);
        end
    endtask

    task automatic run_job(input logic [255:0] key, input logic [1:0] kl, input bit rnd,
                           output int first_v, output int last_x);
        exp_t         e;
        bit           done, pv;
        logic [127:0] prk;
        logic [3:0]   pidx;
        logic         plast;
        q.delete();
        push_model(key, kl);
        first_v = -1;
        last_x  = -1;
        done = 0;
        pv = 0;
        @(negedge CLK);
        key_in = key;
        key_len_in = kl;
        start_in = 1'b1;
        for (int cnt = 1; cnt <= 400 && !done; cnt++) begin
            @(negedge CLK);
            start_in = 1'b0;
            rk_ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pv) begin
                checks++;
                if (rk_valid_out !== 1'b1 || rk_out !== prk || rk_idx_out !== pidx || rk_last_out !== plast) begin
                    errors++;
                    $display("FAIL stable: got v=%b %h/%0d/%b held %h/%0d/%b", rk_valid_out, rk_out, rk_idx_out, rk_last_out, prk, pidx, plast);
                end
            end
            if (rk_valid_out === 1'b1) begin
                if (first_v < 0) first_v = cnt;
                if (rk_ready_in) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_key: got %h/%0d with empty scoreboard", rk_out, rk_idx_out);
                    end else begin
                        e = q.pop_front();
                        if ({rk_out, rk_idx_out, rk_last_out} !== e) begin
                            errors++;
                            $display("FAIL round_key: got %h/%0d/%b exp %h/%0d/%b", rk_out, rk_idx_out, rk_last_out, e.rk, e.idx, e.last);
                        end
                    end
                    got[rk_idx_out] = rk_out;
                    if (rk_last_out === 1'b1) begin
                        done = 1;
                        last_x = cnt;
                    end
                end
            end
            pv = rk_valid_out === 1'b1 && !rk_ready_in;
            prk = rk_out;
            pidx = rk_idx_out;
            plast = rk_last_out;
        end
        checks++;
        if (!done || q.size() != 0) begin
            errors++;
            $display("FAIL job_complete: done=%0d left=%0d exp done=1 left=0", done, q.size());
        end
        @(negedge CLK);
        checks++;
        if (state_out !== 2'd0 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL idle_after: state=%0d busy=%b exp 0/0", state_out, busy_out);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        checks++;
        if ({rk_valid_out, rk_out, rk_idx_out, rk_last_out, state_out, busy_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: v=%b rk=%h idx=%0d last=%b st=%0d busy=%b exp all 0", rk_valid_out, rk_out, rk_idx_out, rk_last_out, state_out, busy_out);
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (state_out !== 2'd0 || rk_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: state=%0d valid=%b exp 0/0", state_out, rk_valid_out);
        end
    endtask

    task automatic test_aes128();
        int f, l;
        run_job(K128, 2'd0, 0, f, l);
        checks++;
        if (f != 5 + int'(OUT_REG) || l != 5 + int'(OUT_REG) + 40) begin
            errors++;
            $display("FAIL aes128_timing: first=%0d last=%0d exp %0d/%0d", f, l, 5 + int'(OUT_REG), 45 + int'(OUT_REG));
        end
        checks++;
        if (got[0] !== 128'h5468617473206D79204B756E67204675) begin
            errors++;
            $display("FAIL aes128_rk0: got %h exp 5468617473206d79204b756e67204675", got[0]);
        end
        checks++;
        if (got[1] !== 128'hE232FCF191129188B159E4E6D679A293) begin
            errors++;
            $display("FAIL aes128_rk1: got %h exp e232fcf191129188b159e4e6d679a293", got[1]);
        end
        checks++;
        if (got[10] !== 128'h28FDDEF86DA4244ACCC0A4FE3B316F26) begin
            errors++;
            $display("FAIL aes128_rk10: got %h exp 28fddef86da4244accc0a4fe3b316f26", got[10]);
        end
    endtask

    task automatic test_aes192();
        int f, l;
        run_job(K192, 2'd1, 0, f, l);
        checks++;
        if (got[1][63:32] !== 32'hFE0C91F7) begin
            errors++;
            $display("FAIL aes192_w6: got %h exp fe0c91f7", got[1][63:32]);
        end
        checks++;
        if (got[12] !== 128'hE98BA06F448C773C8ECC720401002202) begin
            errors++;
            $display("FAIL aes192_rk12: got %h exp e98ba06f448c773c8ecc720401002202", got[12]);
        end
    endtask

    task automatic test_aes256();
        int f, l;
        run_job(K256, 2'd2, 0, f, l);
        checks++;
        if (l != 5 + int'(OUT_REG) + 56) begin
            errors++;
            $display("FAIL aes256_timing: last=%0d exp %0d", l, 61 + int'(OUT_REG));
        end
        checks++;
        if (got[1] !== 128'h1F352C073B6108D72D9810A30914DFF4 || got[2][127:96] !== 32'h9BA35411) begin
            errors++;
            $display("FAIL aes256_rk1_w8: got %h/%h exp 1f352c073b6108d72d9810a30914dff4/9ba35411", got[1], got[2][127:96]);
        end
        checks++;
        if (got[14] !== 128'hFE4890D1E6188D0B046DF344706C631E) begin
            errors++;
            $display("FAIL aes256_rk14: got %h exp fe4890d1e6188d0b046df344706c631e", got[14]);
        end
    endtask

    task automatic test_backpressure();
        int f, l;
        run_job(K256, 2'd2, 1, f, l);
        checks++;
        if (got[14] !== 128'hFE4890D1E6188D0B046DF344706C631E) begin
            errors++;
            $display("FAIL bp_rk14: got %h exp fe4890d1e6188d0b046df344706c631e", got[14]);
        end
    endtask

    task automatic test_abort();
        int f, l;
        bit hit;
        hit = 0;
        @(negedge CLK);
        key_in = K128;
        key_len_in = 2'd0;
        start_in = 1'b1;
        rk_ready_in = 1'b1;
        @(negedge CLK);
        start_in = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            if (rk_valid_out === 1'b1 && rk_idx_out === 4'd5) hit = 1;
            else @(negedge CLK);
        end
        checks++;
        if (!hit || state_out !== 2'd2) begin
            errors++;
            $display("FAIL abort_reach: hit=%0d state=%0d exp 1/2", hit, state_out);
        end
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({rk_valid_out, rk_out, rk_idx_out, rk_last_out, state_out, busy_out} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: v=%b rk=%h idx=%0d last=%b st=%0d busy=%b exp all 0", rk_valid_out, rk_out, rk_idx_out, rk_last_out, state_out, busy_out);
        end
        @(negedge CLK);
        RST = 1'b0;
        run_job(K128, 2'd0, 0, f, l);
        checks++;
        if (got[10] !== 128'h28FDDEF86DA4244ACCC0A4FE3B316F26) begin
            errors++;
            $display("FAIL abort_rerun_rk10: got %h exp 28fddef86da4244accc0a4fe3b316f26", got[10]);
        end
    endtask

    task automatic test_illegal();
        int f, l;
        @(negedge CLK);
        key_in = K256;
        key_len_in = 2'd3;
        start_in = 1'b1;
        rk_ready_in = 1'b1;
        @(negedge CLK);
        start_in = 1'b0;
        repeat (6) @(negedge CLK);
        checks++;
        if (state_out !== 2'd0 || rk_valid_out !== 1'b0 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL illegal_idle: state=%0d valid=%b busy=%b exp 0/0/0", state_out, rk_valid_out, busy_out);
        end
`ifdef AES_KEY_EXPAND_ERR_EN
        checks++;
        if (err_out !== 1'b1) begin
            errors++;
            $display("FAIL err_set: got %b exp 1", err_out);
        end
`endif
        run_job(K128, 2'd0, 0, f, l);
`ifdef AES_KEY_EXPAND_ERR_EN
        checks++;
        if (err_out !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b exp 0", err_out);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_backpressure();
        test_abort();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
